wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file. It drives the register file's write enable, write register and write data ports.
- Merges two result sources: the single-cycle ALU path and the variable-latency memory-load path. Load results are buffered in a small FIFO.
- Keeps a per-register pending-load scoreboard so the decoder can stall on load-use hazards.
- Suppresses every write to register 0.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_fifo.sv | 61 ++++++
 rtl/wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_wb_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------
// wb_pkg : shared types and constants for the writeback arbiter
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package wb_pkg;

  localparam int WIDTH          = 32;
  localparam int SELECTOR       = 5;
  localparam int NUM_REGS       = 2 ** SELECTOR;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef struct packed {
    logic [SELECTOR-1:0] rd;
    logic [WIDTH-1:0]    data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2
  } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------
// wb_fifo : strict-order buffer of load results (wb_req_t entries)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  wb_req_t                  wdata_i,
  output wb_req_t                  head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          w_push, w_pop;

  assign w_push  = push_i && (count_q != FULL_CNT);
  assign w_pop   = pop_i && (count_q != '0);
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + 1'b1;
      if (w_pop)  rptr_q <= rptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------
// wb_arbiter : ALU/load writeback merge, load scoreboard, r0 guard
// Optional macro WB_STALL_CNT_EN adds stall_cnt_o.   Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module wb_arbiter #(
  parameter int  WIDTH      = 32,
  parameter int  SELECTOR   = 5,
  parameter int  FIFO_DEPTH = 4,
  localparam int NUM_REGS   = 2 ** SELECTOR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid_i,
  output logic                alu_ready_o,
  input  logic [SELECTOR-1:0] alu_rd_i,
  input  logic [WIDTH-1:0]    alu_data_i,
  input  logic                mem_valid_i,
  output logic                mem_ready_o,
  input  logic [SELECTOR-1:0] mem_rd_i,
  input  logic [WIDTH-1:0]    mem_data_i,
  input  logic                issue_i,
  input  logic [SELECTOR-1:0] issue_rd_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                Reg_Write_o,
  output logic [SELECTOR-1:0] Write_Register_o,
  output logic [WIDTH-1:0]    Write_Data_o
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt_o
`endif
);

  import wb_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] FULL_CNT = (CW+1)'(FIFO_DEPTH);

  // wb_req_t is sized by the package, so overrides must agree with it.
  if (WIDTH != wb_pkg::WIDTH || SELECTOR != wb_pkg::SELECTOR) begin : g_param_check
    $error("wb_arbiter: WIDTH/SELECTOR must match wb_pkg");
  end

  wb_req_t             w_alu_req, w_mem_req, w_head, w_sel;
  wb_src_e             w_src;
  logic                w_full, w_empty, w_push, w_pop;
  logic [CW:0]         w_count;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                wr_q;
  logic [SELECTOR-1:0] wreg_q;
  logic [WIDTH-1:0]    wdata_q;

  assign w_alu_req = '{rd: alu_rd_i, data: alu_data_i};
  assign w_mem_req = '{rd: mem_rd_i, data: mem_data_i};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_mem_req),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign mem_ready_o = rst && (w_count != FULL_CNT);
  assign alu_ready_o = rst && !w_full;
  assign w_push      = mem_valid_i && mem_ready_o;
  assign w_pop       = (w_src == SRC_MEM);

  // A full buffer forces a drain so loads cannot starve behind the ALU.
  always_comb begin
    w_src = SRC_NONE;
    w_sel = '0;
    if (w_full) begin
      w_src = SRC_MEM;
      w_sel = w_head;
    end else if (alu_valid_i) begin
      w_src = SRC_ALU;
      w_sel = w_alu_req;
    end else if (!w_empty) begin
      w_src = SRC_MEM;
      w_sel = w_head;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (w_pop) busy_d[w_head.rd] = 1'b0;
    if (issue_i && (issue_rd_i != '0)) busy_d[issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      wr_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (w_src != SRC_NONE) begin
        wr_q    <= (w_sel.rd != '0);
        wreg_q  <= w_sel.rd;
        wdata_q <= w_sel.data;
      end else begin
        wr_q    <= 1'b0;
      end
    end
  end

  assign busy_o           = busy_q;
  assign Reg_Write_o      = wr_q;
  assign Write_Register_o = wreg_q;
  assign Write_Data_o     = wdata_q;

`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (alu_valid_i && !alu_ready_o && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

`ifndef SYNTHESIS
  a_issue_not_busy: assert property (@(posedge clk) disable iff (!rst)
    issue_i |-> !busy_q[issue_rd_i]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------
// tb_wb_arbiter : directed vector bench for wb_arbiter
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid_i = 1'b0, mem_valid_i = 1'b0, issue_i = 1'b0;
  logic [4:0]  alu_rd_i = '0, mem_rd_i = '0, issue_rd_i = '0;
  logic [31:0] alu_data_i = '0, mem_data_i = '0;
  logic        alu_ready_o, mem_ready_o, Reg_Write_o;
  logic [31:0] busy_o;
  logic [4:0]  Write_Register_o;
  logic [31:0] Write_Data_o;
`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  wb_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .alu_valid_i      (alu_valid_i),
    .alu_ready_o      (alu_ready_o),
    .alu_rd_i         (alu_rd_i),
    .alu_data_i       (alu_data_i),
    .mem_valid_i      (mem_valid_i),
    .mem_ready_o      (mem_ready_o),
    .mem_rd_i         (mem_rd_i),
    .mem_data_i       (mem_data_i),
    .issue_i          (issue_i),
    .issue_rd_i       (issue_rd_i),
    .busy_o           (busy_o),
    .Reg_Write_o      (Reg_Write_o),
    .Write_Register_o (Write_Register_o),
    .Write_Data_o     (Write_Data_o)
`ifdef WB_STALL_CNT_EN
    ,
    .stall_cnt_o      (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic wr, input logic [4:0] rg, input logic [31:0] data);
    chk({tag, ".wr"},   Reg_Write_o, wr);
    chk({tag, ".reg"},  Write_Register_o, rg);
    chk({tag, ".data"}, Write_Data_o, data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
    mem_valid_i = 0; mem_rd_i = 0; mem_data_i = 0;
    issue_i = 0; issue_rd_i = 0;
  endtask

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] adata;
    logic        mv;  logic [4:0] mrd; logic [31:0] mdata;
    logic        iss; logic [4:0] ird;
    logic        e_ar; logic e_mr;
    logic        e_wr; logic [4:0] e_reg; logic [31:0] e_data; logic [31:0] e_busy;
  } vec_t;

  vec_t tbl [8];

  initial begin
    //            av ard  adata         mv mrd mdata    iss ird ar mr wr reg  data          busy
    tbl[0] = '{1, 5, 32'hDEAD_BEEF, 0, 0, 32'h0,  0, 0,  1, 1, 1, 5, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{1, 0, 32'h1234,      0, 0, 32'h0,  1, 0,  1, 1, 0, 0, 32'h1234,      32'h0};
    tbl[2] = '{0, 0, 32'h0,         0, 0, 32'h0,  1, 9,  1, 1, 0, 0, 32'h1234,      32'h200};
    tbl[3] = '{0, 0, 32'h0,         1, 9, 32'h55, 0, 0,  1, 1, 0, 0, 32'h1234,      32'h200};
    tbl[4] = '{0, 0, 32'h0,         0, 0, 32'h0,  0, 0,  1, 1, 1, 9, 32'h55,        32'h0};
    tbl[5] = '{1, 3, 32'hAAAA,      1, 2, 32'h77, 0, 0,  1, 1, 1, 3, 32'hAAAA,      32'h0};
    tbl[6] = '{0, 0, 32'h0,         0, 0, 32'h0,  0, 0,  1, 1, 1, 2, 32'h77,        32'h0};
    tbl[7] = '{0, 0, 32'h0,         0, 0, 32'h0,  0, 0,  1, 1, 0, 2, 32'h77,        32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.alu_ready", alu_ready_o, 0);
    chk("rst.mem_ready", mem_ready_o, 0);
    chk("rst.busy", busy_o, 0);
    chk_wr("rst", 0, 0, 0);
`ifdef WB_STALL_CNT_EN
    chk("rst.stall", stall_cnt_o, 0);
`endif
    rst = 1;

    for (int i = 0; i < 8; i++) begin
      alu_valid_i = tbl[i].av;  alu_rd_i = tbl[i].ard; alu_data_i = tbl[i].adata;
      mem_valid_i = tbl[i].mv;  mem_rd_i = tbl[i].mrd; mem_data_i = tbl[i].mdata;
      issue_i     = tbl[i].iss; issue_rd_i = tbl[i].ird;
      #1;
      chk($sformatf("vec%0d.alu_ready", i), alu_ready_o, tbl[i].e_ar);
      chk($sformatf("vec%0d.mem_ready", i), mem_ready_o, tbl[i].e_mr);
      tick();
      chk_wr($sformatf("vec%0d", i), tbl[i].e_wr, tbl[i].e_reg, tbl[i].e_data);
      chk($sformatf("vec%0d.busy", i), busy_o, tbl[i].e_busy);
    end
    clear_inputs();

    // Contention: ALU held valid while four loads fill the buffer
    for (int i = 0; i < 4; i++) begin
      alu_valid_i = 1; alu_rd_i = 10; alu_data_i = 32'hA0 + i;
      mem_valid_i = 1; mem_rd_i = 5'(i + 1); mem_data_i = 32'h101 + i;
      #1;
      chk($sformatf("fill%0d.alu_ready", i), alu_ready_o, 1);
      chk($sformatf("fill%0d.mem_ready", i), mem_ready_o, 1);
      tick();
      chk_wr($sformatf("fill%0d", i), 1, 10, 32'hA0 + i);
    end
    alu_data_i = 32'hAF; mem_rd_i = 5; mem_data_i = 32'h105;
    #1;
    chk("full.alu_ready", alu_ready_o, 0);
    chk("full.mem_ready", mem_ready_o, 0);
    tick();
    chk_wr("drain1", 1, 1, 32'h101);
`ifdef WB_STALL_CNT_EN
    chk("full.stall", stall_cnt_o, 1);
`endif
    clear_inputs();
    for (int j = 2; j <= 4; j++) begin
      tick();
      chk_wr($sformatf("drain%0d", j), 1, 5'(j), 32'h100 + j);
    end
    tick();
    chk_wr("drain_end", 0, 4, 32'h104);

    // Reset mid-operation with three queued loads pending
    for (int i = 0; i < 3; i++) begin
      alu_valid_i = 1; alu_rd_i = 12; alu_data_i = 32'hC0 + i;
      mem_valid_i = 1; mem_rd_i = 5'(9 + i); mem_data_i = 32'h900 + i;
      issue_i = 1; issue_rd_i = 5'(9 + i);
      tick();
      chk_wr($sformatf("pre_rst%0d", i), 1, 12, 32'hC0 + i);
    end
    clear_inputs();
    chk("pre_rst.busy", busy_o, 32'h0000_0E00);
    #2 rst = 0;
    #1;
    chk("mid_rst.busy", busy_o, 0);
    chk("mid_rst.alu_ready", alu_ready_o, 0);
    chk("mid_rst.mem_ready", mem_ready_o, 0);
    chk_wr("mid_rst", 0, 0, 0);
`ifdef WB_STALL_CNT_EN
    chk("mid_rst.stall", stall_cnt_o, 0);
`endif
    tick();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_wr($sformatf("post_rst%0d", i), 0, 0, 0);
      chk($sformatf("post_rst%0d.busy", i), busy_o, 0);
    end

    // Simultaneous issue and pop of the same register: set wins
    mem_valid_i = 1; mem_rd_i = 7; mem_data_i = 32'h77;
    tick();
    chk_wr("sim_push", 0, 0, 0);
    clear_inputs();
    issue_i = 1; issue_rd_i = 7;
    tick();
    clear_inputs();
    chk_wr("sim_pop", 1, 7, 32'h77);
    chk("sim.busy", busy_o, 32'h0000_0080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
